ipv4_local_lut_ctrl: RTL and testbench

//  Initiator side of the IPv4 local-address table access interface. Accepts single read/write

---
 rtl/ipv4_local_lut_ctrl.sv | 128 ++++++++++++
 tb/tb_ipv4_local_lut_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipv4_local_lut_ctrl.sv
// IPv4 local-address LUT access controller.
// Issues one rd/wr request per command and waits for the table ack.
module ipv4_local_lut_ctrl #(
    parameter int IPV4_LOCAL_LUT_ROWS     = 32,
    parameter int IPV4_LOCAL_LUT_ROW_BITS = 5,
    parameter int ACK_TIMEOUT_CYCLES      = 16
) (
    input  logic                               Bus2IP_Clk,
    input  logic                               Bus2IP_Reset,
    input  logic                               i_cmd_valid,
    output logic                               o_cmd_ready,
    input  logic                               i_cmd_is_wr,
    input  logic [IPV4_LOCAL_LUT_ROW_BITS-1:0] i_cmd_row,
    input  logic [31:0]                        i_cmd_wdata,
    output logic                               o_done,
    output logic [31:0]                        o_rdata,
    output logic                               o_err_range,
    output logic                               o_err_timeout,
    output logic [15:0]                        o_rd_count,
    output logic [15:0]                        o_wr_count,
    output logic                               o_ipv4_local_lut_rd_req,
    input  logic                               i_ipv4_local_lut_rd_ack,
    output logic [IPV4_LOCAL_LUT_ROW_BITS-1:0] o_ipv4_local_lut_rd_addr,
    input  logic [31:0]                        i_ipv4_local_lut_rd_ipv4_addr,
    output logic                               o_ipv4_local_lut_wr_req,
    input  logic                               i_ipv4_local_lut_wr_ack,
    output logic [IPV4_LOCAL_LUT_ROW_BITS-1:0] o_ipv4_local_lut_wr_addr,
    output logic [31:0]                        o_ipv4_local_lut_wr_ipv4_addr
);

    localparam int RB = IPV4_LOCAL_LUT_ROW_BITS;
    localparam int TW = $clog2(ACK_TIMEOUT_CYCLES);
    localparam logic [RB:0]   ROWS_W  = (RB+1)'(IPV4_LOCAL_LUT_ROWS);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          op_wr_q;
    logic [RB-1:0] row_q;
    logic [31:0]   wdata_q;
    logic [TW-1:0] tmo_q;

    logic accept, out_of_range, ack, expire;
    logic rd_req_d, wr_req_d;

    assign accept       = (state_q == IDLE) && i_cmd_valid;
    assign out_of_range = {1'b0, i_cmd_row} >= ROWS_W;
    assign ack          = op_wr_q ? i_ipv4_local_lut_wr_ack
                                  : i_ipv4_local_lut_rd_ack;
    assign expire       = (tmo_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (out_of_range) begin
                        state_d = DONE;
                    end else begin
                        state_d  = REQ;
                        rd_req_d = !i_cmd_is_wr;
                        wr_req_d = i_cmd_is_wr;
                    end
                end
            end
            REQ:  state_d = WAIT;
            // An ack on the expiry cycle still counts as success.
            WAIT: if (ack || expire) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q                 <= IDLE;
            o_cmd_ready             <= 1'b1;
            o_done                  <= 1'b0;
            o_ipv4_local_lut_rd_req <= 1'b0;
            o_ipv4_local_lut_wr_req <= 1'b0;
            op_wr_q                 <= 1'b0;
            row_q                   <= '0;
            wdata_q                 <= '0;
            tmo_q                   <= '0;
            o_rdata                 <= '0;
            o_err_range             <= 1'b0;
            o_err_timeout           <= 1'b0;
            o_rd_count              <= '0;
            o_wr_count              <= '0;
        end else begin
            state_q                 <= state_d;
            o_cmd_ready             <= (state_d == IDLE);
            o_done                  <= (state_d == DONE);
            o_ipv4_local_lut_rd_req <= rd_req_d;
            o_ipv4_local_lut_wr_req <= wr_req_d;
            if (accept) begin
                op_wr_q       <= i_cmd_is_wr;
                row_q         <= i_cmd_row;
                wdata_q       <= i_cmd_wdata;
                o_err_range   <= out_of_range;
                o_err_timeout <= 1'b0;
            end
            if (state_q == REQ) tmo_q <= '0;
            if (state_q == WAIT) begin
                if (ack) begin
                    if (op_wr_q) begin
                        o_wr_count <= o_wr_count + 16'd1;
                    end else begin
                        o_rd_count <= o_rd_count + 16'd1;
                        o_rdata    <= i_ipv4_local_lut_rd_ipv4_addr;
                    end
                end else if (expire) begin
                    o_err_timeout <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    assign o_ipv4_local_lut_rd_addr      = row_q;
    assign o_ipv4_local_lut_wr_addr      = row_q;
    assign o_ipv4_local_lut_wr_ipv4_addr = wdata_q;

endmodule

// File: tb/tb_ipv4_local_lut_ctrl.sv
// Randomized bench for ipv4_local_lut_ctrl against a per-command
// transaction model of latency, table traffic, status and counters.
module tb_ipv4_local_lut_ctrl;

    localparam int ROWS = 32;
    localparam int RB   = 6;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_is_wr;
    logic [RB-1:0] cmd_row;
    logic [31:0]   cmd_wdata;
    logic          done;
    logic [31:0]   rdata;
    logic          err_range, err_timeout;
    logic [15:0]   rd_count, wr_count;
    logic          rd_req, rd_ack, wr_req, wr_ack;
    logic [RB-1:0] rd_addr, wr_addr;
    logic [31:0]   rd_data, wr_data;

    always #5 clk = ~clk;

    ipv4_local_lut_ctrl #(
        .IPV4_LOCAL_LUT_ROWS(ROWS),
        .IPV4_LOCAL_LUT_ROW_BITS(RB),
        .ACK_TIMEOUT_CYCLES(TO)
    ) dut (
        .Bus2IP_Clk(clk),
        .Bus2IP_Reset(rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_is_wr(cmd_is_wr),
        .i_cmd_row(cmd_row),
        .i_cmd_wdata(cmd_wdata),
        .o_done(done),
        .o_rdata(rdata),
        .o_err_range(err_range),
        .o_err_timeout(err_timeout),
        .o_rd_count(rd_count),
        .o_wr_count(wr_count),
        .o_ipv4_local_lut_rd_req(rd_req),
        .i_ipv4_local_lut_rd_ack(rd_ack),
        .o_ipv4_local_lut_rd_addr(rd_addr),
        .i_ipv4_local_lut_rd_ipv4_addr(rd_data),
        .o_ipv4_local_lut_wr_req(wr_req),
        .i_ipv4_local_lut_wr_ack(wr_ack),
        .o_ipv4_local_lut_wr_addr(wr_addr),
        .o_ipv4_local_lut_wr_ipv4_addr(wr_data)
    );

    int total  = 0;
    int passed = 0;

    // Table contents and expected controller status.
    logic [31:0] tbl [ROWS];
    logic [31:0] m_rdata;
    logic [15:0] m_rd, m_wr;
    logic        m_er, m_et;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input bit erq, input bit ewq,
                            input bit edone, input bit erdy);
        chk({tag, "/rd_req"}, 32'(rd_req), 32'(erq));
        chk({tag, "/wr_req"}, 32'(wr_req), 32'(ewq));
        chk({tag, "/done"}, 32'(done), 32'(edone));
        chk({tag, "/ready"}, 32'(cmd_ready), 32'(erdy));
        chk({tag, "/err_range"}, 32'(err_range), 32'(m_er));
        chk({tag, "/err_timeout"}, 32'(err_timeout), 32'(m_et));
        chk({tag, "/rdata"}, rdata, m_rdata);
        chk({tag, "/rd_count"}, 32'(rd_count), 32'(m_rd));
        chk({tag, "/wr_count"}, 32'(wr_count), 32'(m_wr));
    endtask

    // Idle cycles, optionally with stray acks that must be ignored.
    task automatic idle(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b1);
            rd_ack  = stray ? 1'($urandom) : 1'b0;
            wr_ack  = stray ? 1'($urandom) : 1'b0;
            rd_data = $urandom;
        end
    endtask

    // Called at a negedge with the controller idle. d = WAIT cycles
    // before the ack (d < 0: never). noise adds opposite-type acks
    // during WAIT and matching acks in REQ/DONE.
    task automatic run_cmd(input bit wr, input int row, input logic [31:0] wd,
                           input int d, input bit noise, output int done_k);
        bit inr, succ;
        int off, ackk;
        bit mack, oack;
        inr  = row < ROWS;
        succ = inr && d >= 0 && d <= TO - 1;
        off  = !inr ? 0 : (succ ? 2 + d : 1 + TO);
        ackk = (inr && d >= 0) ? 1 + d : -1;
        done_k = -1;
        chk("pre/ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_is_wr = wr;
        cmd_row   = RB'(row);
        cmd_wdata = wd;
        @(posedge clk);
        for (int k = 0; k <= off + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cmd_valid = 1'b0;
                cmd_is_wr = 1'($urandom);
                cmd_row   = RB'($urandom);
                cmd_wdata = $urandom;
                m_er = !inr;
                m_et = 1'b0;
            end
            if (k == off) begin
                if (inr && succ) begin
                    if (wr) begin
                        tbl[row] = wd;
                        m_wr++;
                    end else begin
                        m_rdata = tbl[row];
                        m_rd++;
                    end
                end else if (inr) begin
                    m_et = 1'b1;
                end
            end
            if (done === 1'b1 && done_k < 0) done_k = k;
            chk_outs("cmd", k == 0 && inr && !wr, k == 0 && inr && wr,
                     k == off, k > off);
            if (inr && k <= off) begin
                if (wr) begin
                    chk("cmd/wr_addr", 32'(wr_addr), 32'(row));
                    chk("cmd/wr_data", wr_data, wd);
                end else begin
                    chk("cmd/rd_addr", 32'(rd_addr), 32'(row));
                end
            end
            mack = (k == ackk) || (noise && (k == 0 || k == off));
            oack = noise && k >= 1 && k < off;
            if (k == off + 1) begin
                mack = 1'b0;
                oack = 1'b0;
            end
            rd_ack  = wr ? oack : mack;
            wr_ack  = wr ? mack : oack;
            rd_data = (!wr && inr && k == ackk) ? tbl[row] : $urandom;
        end
    endtask

    task automatic reset_mid();
        cmd_valid = 1'b1;
        cmd_is_wr = 1'b0;
        cmd_row   = RB'(5);
        cmd_wdata = 32'h0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rd_ack    = 1'b0;
            wr_ack    = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_rd    = '0;
        m_wr    = '0;
        m_rdata = '0;
        m_er    = 1'b0;
        m_et    = 1'b0;
        chk_outs("rstmid", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rstmid/rd_addr", 32'(rd_addr), 32'd0);
        chk("rstmid/wr_data", wr_data, 32'd0);
        idle(3, 1'b0);
    endtask

    int dk;
    int dly, sel, row;

    initial begin
        for (int i = 0; i < ROWS; i++) tbl[i] = $urandom;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_is_wr = 1'b0;
        cmd_row   = '0;
        cmd_wdata = '0;
        rd_ack    = 1'b0;
        wr_ack    = 1'b0;
        rd_data   = '0;
        m_rdata   = '0;
        m_rd      = '0;
        m_wr      = '0;
        m_er      = 1'b0;
        m_et      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset/wr_addr", 32'(wr_addr), 32'd0);
        idle(2, 1'b0);

        run_cmd(1'b1, 3, 32'h0A000001, 0, 1'b0, dk);
        chk("t1/latency", 32'(dk), 32'd2);
        chk("t1/wr_count", 32'(wr_count), 32'd1);

        run_cmd(1'b0, 3, 32'h0, 0, 1'b0, dk);
        chk("t2/latency", 32'(dk), 32'd2);
        chk("t2/rdata", rdata, 32'h0A000001);
        chk("t2/rd_count", 32'(rd_count), 32'd1);

        run_cmd(1'b0, 32, 32'h0, 0, 1'b0, dk);
        chk("t3/latency", 32'(dk), 32'd0);
        chk("t3/err_range", 32'(err_range), 32'd1);
        chk("t3/rdata", rdata, 32'h0A000001);

        run_cmd(1'b0, 7, 32'h0, -1, 1'b0, dk);
        chk("t4/latency", 32'(dk), 32'd17);
        chk("t4/err_timeout", 32'(err_timeout), 32'd1);
        idle(4, 1'b1);
        chk("t4/rd_count", 32'(rd_count), 32'd1);
        chk("t4/wr_count", 32'(wr_count), 32'd1);

        tbl[9] = 32'hC0A80109;
        run_cmd(1'b0, 9, 32'h0, TO - 1, 1'b1, dk);
        chk("t5/latency", 32'(dk), 32'd17);
        chk("t5/err_timeout", 32'(err_timeout), 32'd0);
        chk("t5/rdata", rdata, 32'hC0A80109);

        reset_mid();
        run_cmd(1'b1, 1, 32'h0A0000FE, 1, 1'b0, dk);
        chk("t6/latency", 32'(dk), 32'd3);
        chk("t6/wr_count", 32'(wr_count), 32'd1);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      dly = $urandom_range(0, 3);
            else if (sel == 6) dly = TO - 1;
            else if (sel == 7) dly = TO;
            else if (sel == 8) dly = -1;
            else               dly = $urandom_range(4, TO - 2);
            row = ($urandom_range(0, 7) == 0) ? $urandom_range(ROWS, 63)
                                              : $urandom_range(0, ROWS - 1);
            run_cmd(1'($urandom), row, $urandom, dly, 1'($urandom), dk);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
